// File: rtl/reg_writeback.sv
// reg_writeback: write-side companion to the integer register file.
//
// Merges single-cycle ALU results and long-latency load results onto the
// register file's single write port. ALU results always win; load results
// queue in a small FIFO until the ALU leaves a free cycle. A pending-load
// scoreboard flags source registers that still await a load writeback.
//
// Optional feature: define WB_FWD_EN to build the write-port forwarding
// comparators; without it the fwd_* outputs are tied to 0.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   alu_valid/alu_rd/alu_data  ALU result (no backpressure)
//   ld_issue_valid/ld_issue_rd load issued, reserve destination
//   ld_valid/ld_rd/ld_data     load result offered, ld_ready accepts it
//   rs1, rs2 -> hz_rs1, hz_rs2 pending-load hazard queries
//   rd, data_des, reg_wen      register file write port (registered)
//   fwd_a/b_valid, fwd_a/b     forwarding of the in-flight write
//   ld_count                   FIFO occupancy
module reg_writeback #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [WIDTH-1:0]         alu_data,
  input  logic                     ld_issue_valid,
  input  logic [4:0]               ld_issue_rd,
  input  logic                     ld_valid,
  input  logic [4:0]               ld_rd,
  input  logic [WIDTH-1:0]         ld_data,
  output logic                     ld_ready,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     hz_rs1,
  output logic                     hz_rs2,
  output logic [4:0]               rd,
  output logic [WIDTH-1:0]         data_des,
  output logic                     reg_wen,
  output logic                     fwd_a_valid,
  output logic                     fwd_b_valid,
  output logic [WIDTH-1:0]         fwd_a,
  output logic [WIDTH-1:0]         fwd_b,
  output logic [$clog2(DEPTH):0]   ld_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [4:0]       fifo_rd_q   [DEPTH];
  logic [WIDTH-1:0] fifo_data_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [31:0]      pend_q, pend_d;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] data_q;
  logic             wen_q;

  logic             push, pop, fifo_nempty, sel_valid;
  logic [4:0]       sel_rd, head_rd;
  logic [WIDTH-1:0] sel_data;

  // ld_ready looks at the current count only, so a full FIFO stays closed
  // even in a cycle where it also pops.
  assign ld_ready    = rst_n && (count_q != CntW'(DEPTH));
  assign fifo_nempty = (count_q != '0);
  assign head_rd     = fifo_rd_q[rd_ptr_q];

  always_comb begin
    push      = ld_valid && ld_ready;
    pop       = !alu_valid && fifo_nempty;
    sel_valid = alu_valid || fifo_nempty;
    sel_rd    = alu_valid ? alu_rd : head_rd;
    sel_data  = alu_valid ? alu_data : fifo_data_q[rd_ptr_q];

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Clear first so a same-edge re-issue of the committed register wins.
    pend_d = pend_q;
    if (pop) pend_d[head_rd] = 1'b0;
    if (ld_issue_valid && (ld_issue_rd != 5'd0)) pend_d[ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      wen_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      pend_q  <= pend_d;
      wen_q   <= sel_valid && (sel_rd != 5'd0);
      if (sel_valid) begin
        rd_q   <= sel_rd;
        data_q <= sel_data;
      end
    end
  end

  // Storage needs no reset: push is already gated by rst_n through ld_ready.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= ld_rd;
      fifo_data_q[wr_ptr_q] <= ld_data;
    end
  end

  assign rd       = rd_q;
  assign data_des = data_q;
  assign reg_wen  = wen_q;
  assign ld_count = count_q;

  // pend_q[0] is never set, so x0 queries read 0.
  assign hz_rs1 = pend_q[rs1];
  assign hz_rs2 = pend_q[rs2];

`ifdef WB_FWD_EN
  // Covers the cycle before the register file captures the write.
  assign fwd_a_valid = wen_q && (rd_q == rs1) && (rs1 != 5'd0);
  assign fwd_b_valid = wen_q && (rd_q == rs2) && (rs2 != 5'd0);
  assign fwd_a       = data_q;
  assign fwd_b       = data_q;
`else
  assign fwd_a_valid = 1'b0;
  assign fwd_b_valid = 1'b0;
  assign fwd_a       = '0;
  assign fwd_b       = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

  localparam int W = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n, alu_valid, ld_issue_valid, ld_valid;
  logic [4:0]    alu_rd, ld_issue_rd, ld_rd, rs1, rs2;
  logic [W-1:0]  alu_data, ld_data;
  logic          ld_ready, hz_rs1, hz_rs2, reg_wen, fwd_a_valid, fwd_b_valid;
  logic [4:0]    rd;
  logic [W-1:0]  data_des, fwd_a, fwd_b;
  logic [$clog2(D):0] ld_count;

  reg_writeback #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rs1(rs1), .rs2(rs2), .hz_rs1(hz_rs1), .hz_rs2(hz_rs2),
    .rd(rd), .data_des(data_des), .reg_wen(reg_wen),
    .fwd_a_valid(fwd_a_valid), .fwd_b_valid(fwd_b_valid),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of pending load results plus a set of pending regs.
  logic [4:0]   q_rd   [$];
  logic [W-1:0] q_data [$];
  bit           m_pend [32];
  logic         m_wen;
  logic [4:0]   m_rd;
  logic [W-1:0] m_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q_rd.delete();
    q_data.delete();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_wen = 0; m_rd = 0; m_data = 0;
  endtask

  // One clock cycle: drive inputs at negedge, check combinational outputs,
  // advance the model, then check registered outputs after the edge.
  task automatic step(input logic r, input logic av, input logic [4:0] ard,
                      input logic [W-1:0] ad, input logic iv, input logic [4:0] ird,
                      input logic lv, input logic [4:0] lrd, input logic [W-1:0] ldd,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit           ready, sel;
    logic [4:0]   s_rd;
    logic [W-1:0] s_data;
    bit           fa, fb;
    rst_n = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_issue_valid = iv; ld_issue_rd = ird;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd; rs1 = r1; rs2 = r2;
    #1;
    ready = r && (q_rd.size() < D);
    check("ld_ready", ld_ready, ready);
    check("hz_rs1", hz_rs1, m_pend[r1]);
    check("hz_rs2", hz_rs2, m_pend[r2]);
`ifdef WB_FWD_EN
    fa = m_wen && (m_rd == r1) && (r1 != 0);
    fb = m_wen && (m_rd == r2) && (r2 != 0);
    check("fwd_a_valid", fwd_a_valid, fa);
    check("fwd_b_valid", fwd_b_valid, fb);
    if (fa) check("fwd_a", fwd_a, m_data);
    if (fb) check("fwd_b", fwd_b, m_data);
`else
    fa = 0; fb = 0;
    check("fwd_a_valid", fwd_a_valid, fa);
    check("fwd_b", fwd_b, 0);
`endif
    if (!r) begin
      model_clear();
    end else begin
      sel = 0; s_rd = 0; s_data = 0;
      if (av) begin
        sel = 1; s_rd = ard; s_data = ad;
      end else if (q_rd.size() > 0) begin
        sel = 1; s_rd = q_rd.pop_front(); s_data = q_data.pop_front();
        m_pend[s_rd] = 0;
      end
      if (lv && ready) begin
        q_rd.push_back(lrd);
        q_data.push_back(ldd);
      end
      if (iv && ird != 0) m_pend[ird] = 1;
      m_wen = sel && (s_rd != 0);
      if (sel) begin
        m_rd = s_rd; m_data = s_data;
      end
    end
    @(posedge clk);
    #1;
    check("reg_wen", reg_wen, m_wen);
    check("rd", rd, m_rd);
    check("data_des", data_des, m_data);
    check("ld_count", ld_count, q_rd.size());
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] r1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  initial begin
    model_clear();
    rst_n = 0; alu_valid = 0; alu_rd = 0; alu_data = 0; ld_issue_valid = 0;
    ld_issue_rd = 0; ld_valid = 0; ld_rd = 0; ld_data = 0; rs1 = 0; rs2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_reg_wen", reg_wen, 0);
    check("rst_ld_count", ld_count, 0);
    check("rst_rd", rd, 0);
    check("rst_data", data_des, 0);

    // Single ALU write, forwarded to rs1 while the register file catches up.
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    check("alu_rd", rd, 5);
    check("alu_data", data_des, 32'hDEADBEEF);
    check("alu_wen", reg_wen, 1);
    idle(5);

    // x0 suppression on both paths.
    step(1, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    check("x0_alu_wen", reg_wen, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 32'h55, 0, 0);
    check("x0_ld_count", ld_count, 1);
    idle(0);
    check("x0_ld_wen", reg_wen, 0);
    check("x0_ld_drain", ld_count, 0);

    // Collision: ALU first, load one cycle later.
    step(1, 1, 3, 32'h11, 0, 0, 1, 7, 32'h22, 0, 0);
    check("col_rd0", rd, 3);
    check("col_data0", data_des, 32'h11);
    idle(0);
    check("col_rd1", rd, 7);
    check("col_data1", data_des, 32'h22);
    check("col_wen1", reg_wen, 1);

    // Backpressure: ALU every cycle fills the FIFO, then drains in order.
    for (int i = 0; i < 4; i++)
      step(1, 1, 5'(20 + i), 32'(i), 0, 0, 1, 5'(10 + i), 32'(100 + i), 0, 0);
    check("bp_full", ld_count, 4);
    step(1, 1, 25, 32'h77, 0, 0, 1, 30, 32'h99, 0, 0);
    check("bp_count_hold", ld_count, 4);
    for (int i = 0; i < 4; i++) begin
      idle(0);
      check("bp_drain_rd", rd, 10 + i);
      check("bp_drain_data", data_des, 100 + i);
      check("bp_drain_wen", reg_wen, 1);
    end
    check("bp_empty", ld_count, 0);

    // Scoreboard set, clear on commit, and set-wins on the commit edge.
    step(1, 0, 0, 0, 1, 9, 0, 0, 0, 9, 0);
    step(1, 0, 0, 0, 0, 0, 1, 9, 32'hA5, 9, 0);
    check("sb_set", hz_rs1, 1);
    idle(9);
    check("sb_clear", hz_rs1, 0);
    step(1, 0, 0, 0, 1, 9, 1, 9, 32'hA6, 9, 0);
    step(1, 0, 0, 0, 1, 9, 0, 0, 0, 9, 0);
    check("sb_reissue", hz_rs1, 1);

    // Reset with queued entries and a pending register.
    step(1, 1, 1, 1, 1, 4, 1, 2, 2, 4, 0);
    step(1, 1, 1, 1, 0, 0, 1, 3, 3, 4, 0);
    step(1, 1, 1, 1, 0, 0, 1, 6, 6, 4, 0);
    check("pre_rst_count", ld_count, 3);
    step(0, 1, 8, 8, 1, 8, 1, 8, 8, 4, 8);
    check("post_rst_count", ld_count, 0);
    check("post_rst_wen", reg_wen, 0);
    check("post_rst_hz", hz_rs1, 0);
    idle(4);

    // Randomized traffic over a narrow register range to force hits.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 60) != 0), ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side companion to the integer register file. It collects results from the single-cycle ALU path and from the long-latency load path, arbitrates them onto the register file's single write port, and drives the `rd`, `data_des` and `reg_wen` outputs. A load-result FIFO absorbs collisions. A pending-destination scoreboard tells the issue stage which source registers still await a load writeback.

## Interface
- `WIDTH`, 32, data width; must match the register file.
- `DEPTH`, 4, load-result FIFO entries; power of two, ≥2.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `alu_valid`  in  1  ALU result present this cycle; no backpressure.
- `alu_rd`  in  5  ALU destination.
- `alu_data`  in  WIDTH  ALU result.
- `ld_issue_valid`  in  1  load issued; reserve its destination.
- `ld_issue_rd`  in  5  destination of the issued load.
- `ld_valid`  in  1  load result offered.
- `ld_rd`  in  5  load destination.
- `ld_data`  in  WIDTH  load result.
- `ld_ready`  out  1  FIFO can accept a load result.
- `rs1`, `rs2`  in  5 each  issue-stage source queries.
- `hz_rs1`, `hz_rs2`  out  1 each  queried register has a pending load.
- `rd`  out  5  register file write address.
- `data_des`  out  WIDTH  register file write data.
- `reg_wen`  out  1  register file write enable.
- `fwd_a_valid`, `fwd_b_valid`  out  1 each  forwarding hit for `rs1`/`rs2`.
- `fwd_a`, `fwd_b`  out  WIDTH each  forwarded data.
- `ld_count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Load accept: a load result is pushed when `ld_valid && ld_ready` are both high. `ld_ready = rst_n && (ld_count != DEPTH)`.
- Arbitration, evaluated each cycle:
  - If `alu_valid` is high, the ALU result is selected.
  - Otherwise, if the FIFO is non-empty, the FIFO head is selected and popped.
  - Otherwise nothing is selected.
- The ALU path always wins. Loads can starve only while the ALU issues every cycle.
- The selected result is registered into `rd`/`data_des`, and `reg_wen` is set to 1.
  - Exception: if the selected `rd == 0`, `reg_wen` is set to 0. A FIFO entry with `rd == 0` is still popped.
- With no selection, `reg_wen` is set to 0. `rd` and `data_des` hold their last values.
- Scoreboard: 32-bit `pend`.
  - Set: `ld_issue_valid` sets `pend[ld_issue_rd]`. Register 0 is never set.
  - Clear: `pend[r]` clears on the edge where a FIFO entry with `rd == r` is committed to the write registers.
  - Same register set and cleared on the same edge: set wins.
- `hz_rs1 = pend[rs1]` and `hz_rs2 = pend[rs2]`, combinational. Both read 0 for register 0.
- `ld_count` tracks occupancy. It is incremented on push and decremented on pop; a simultaneous push and pop leaves it unchanged.
- Reset values: FIFO empty, `ld_count = 0`, `pend = 0`, `rd = 0`, `data_des = 0`, `reg_wen = 0`, all `fwd_*` = 0.
  - Reset mid-operation discards all queued and pending state. A push or issue on the reset edge is ignored.

## Timing
- ALU result to `reg_wen`: 1 cycle. The register file writes on the following edge, so the array updates 2 edges after `alu_valid`.
- Load result to `reg_wen`: at least 2 cycles (push edge, then pop/register edge). More cycles while the ALU holds priority.
- Push into an empty FIFO: the entry becomes visible for pop in the next cycle. There is no same-cycle pass-through.
- Full FIFO with a pop in the same cycle: `ld_ready` stays 0 that cycle, because it is computed from the current `ld_count`.
- FIFO pointers wrap modulo `DEPTH`.
- `hz_*` and `fwd_*` are combinational from registered state plus `rs1`/`rs2`.

## Configuration
- `WB_FWD_EN` defined:
  - `fwd_a_valid = reg_wen && rd == rs1 && rs1 != 0`, with `fwd_a = data_des`. `fwd_b_valid` and `fwd_b` are formed the same way from `rs2`.
  - This covers the cycle in which the register file has not yet captured the write.
- `WB_FWD_EN` undefined: the `fwd_*` ports are tied to 0 and no comparators are built.

## Test plan
- Single ALU write: `alu_valid = 1`, `alu_rd = 5`, `alu_data = 0xDEADBEEF` → next cycle `reg_wen = 1`, `rd = 5`, `data_des = 0xDEADBEEF`. With `WB_FWD_EN` and `rs1 = 5`: `fwd_a_valid = 1`, `fwd_a = 0xDEADBEEF`.
- x0 suppression: ALU write to `rd = 0` → `reg_wen = 0`. Load result to `rd = 0` → popped, `ld_count` returns to 0, `reg_wen` never 1.
- Collision: same cycle ALU (`rd = 3`, `0x11`) and load (`rd = 7`, `0x22`) → cycle+1 writes `x3 = 0x11`, cycle+2 writes `x7 = 0x22`.
- Backpressure: ALU valid every cycle, push 4 loads → `ld_count = 4`, `ld_ready = 0`. Drop ALU → FIFO drains in 4 consecutive cycles in push order.
- Scoreboard: issue load `rd = 9` → `hz_rs1 = 1` for `rs1 = 9`. Result committed → `hz_rs1 = 0` after that edge. Re-issue to `rd = 9` on the commit edge → stays 1.
- Reset: `rst_n = 0` for one cycle with 3 queued entries and `pend[4] = 1` → `ld_count = 0`, `pend = 0`, `reg_wen = 0`, `ld_ready = 0` during reset, then 1.
